// File: rtl/jtframe_objscan.sv
// ============================================================================
//  Module      : jtframe_objscan
//  Description : Object-table scanner. On each hs rising edge it walks the
//                object RAM and issues one draw/busy handshaked request per
//                16x16 object that intersects the latched render line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_objscan #(
  parameter int CW = 12,  // code width
  parameter int PW = 8,   // pixel width, palette is PW-4 bits
  parameter int OW = 7    // object index width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hs_i,
  input  logic [8:0]    vrender_i,
  output logic [OW+1:0] ram_addr_o,
  input  logic [15:0]   ram_data_i,
  output logic          draw_o,
  input  logic          busy_i,
  output logic [CW-1:0] code_o,
  output logic [8:0]    xpos_o,
  output logic [3:0]    ysub_o,
  output logic          hflip_o,
  output logic          vflip_o,
  output logic [PW-5:0] pal_o,
  output logic          scan_done_o,
  output logic          overrun_o
);

  localparam logic [3:0] c_ST_IDLE  = 4'd0;
  localparam logic [3:0] c_ST_RDY   = 4'd1;
  localparam logic [3:0] c_ST_CHK   = 4'd2;
  localparam logic [3:0] c_ST_RD1   = 4'd3;
  localparam logic [3:0] c_ST_RD2   = 4'd4;
  localparam logic [3:0] c_ST_RD3   = 4'd5;
  localparam logic [3:0] c_ST_ISSUE = 4'd6;
  localparam logic [3:0] c_ST_HOLD  = 4'd7;
  localparam logic [3:0] c_ST_WAIT  = 4'd8;
  localparam logic [3:0] c_ST_DONE  = 4'd9;

  localparam logic [OW-1:0] c_IDX_ONE = {{(OW-1){1'b0}}, 1'b1};

  logic [3:0]    state_q, state_d;
  logic          hs_q, hs_prev_q;
  logic [OW-1:0] idx_q, idx_d;
  logic [8:0]    vl_q, vl_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] code_q, code_d;
  logic [8:0]    xpos_q, xpos_d;
  logic [3:0]    ysub_q, ysub_d;
  logic          hflip_q, hflip_d;
  logic          vflip_q, vflip_d;
  logic [PW-5:0] pal_q, pal_d;

  logic          w_edge;
  logic          w_last;
  logic          w_visible;
  logic          w_busy_st;
  logic          w_scan_st;
  logic [8:0]    w_ydiff;
  logic          w_unused_data;

  // Word 0 is on ram_data_i while in CHK; the modulo-512 subtract handles
  // objects that straddle line 511/0.
  assign w_ydiff       = vl_q - ram_data_i[8:0];
  assign w_visible     = ram_data_i[15] && (w_ydiff[8:4] == 5'd0);
  assign w_edge        = hs_q & ~hs_prev_q;
  assign w_last        = &idx_q;
  assign w_busy_st     = (state_q == c_ST_ISSUE) || (state_q == c_ST_HOLD) ||
                         (state_q == c_ST_WAIT);
  assign w_scan_st     = (state_q != c_ST_IDLE) && (state_q != c_ST_DONE);
  assign w_unused_data = ^ram_data_i;

  // Registered hs edge detector: edge is acted on the clock after hs is seen high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
    end else begin
      hs_q      <= hs_i;
      hs_prev_q <= hs_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an hs edge restarts the walk except while a request is out
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (w_edge) state_d = c_ST_RDY;
      c_ST_RDY:   state_d = w_edge ? c_ST_RDY : c_ST_CHK;
      c_ST_CHK: begin
        if (w_edge)         state_d = c_ST_RDY;
        else if (w_visible) state_d = c_ST_RD1;
        else if (w_last)    state_d = c_ST_DONE;
        else                state_d = c_ST_RDY;
      end
      c_ST_RD1:   state_d = w_edge ? c_ST_RDY : c_ST_RD2;
      c_ST_RD2:   state_d = w_edge ? c_ST_RDY : c_ST_RD3;
      c_ST_RD3:   state_d = w_edge ? c_ST_RDY : c_ST_ISSUE;
      c_ST_ISSUE: state_d = c_ST_HOLD;
      c_ST_HOLD:  state_d = c_ST_WAIT;
      c_ST_WAIT: begin
        if (!busy_i) begin
          if (pend_q || w_edge) state_d = c_ST_RDY;
          else if (w_last)      state_d = c_ST_DONE;
          else                  state_d = c_ST_RDY;
        end
      end
      c_ST_DONE:  state_d = w_edge ? c_ST_RDY : c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Datapath next values: index, latched line, pending restart and object fields
  always_comb begin
    idx_d   = idx_q;
    vl_d    = vl_q;
    pend_d  = pend_q;
    code_d  = code_q;
    xpos_d  = xpos_q;
    ysub_d  = ysub_q;
    hflip_d = hflip_q;
    vflip_d = vflip_q;
    pal_d   = pal_q;

    if (w_edge) begin
      vl_d = vrender_i;
      if (w_busy_st) pend_d = 1'b1;
      else           idx_d  = '0;
    end

    if (!w_edge) begin
      case (state_q)
        c_ST_CHK: begin
          if (w_visible)    ysub_d = w_ydiff[3:0];
          else if (!w_last) idx_d  = idx_q + c_IDX_ONE;
        end
        c_ST_RD1: code_d = ram_data_i[CW-1:0];
        c_ST_RD2: xpos_d = ram_data_i[8:0];
        c_ST_RD3: begin
          hflip_d = ram_data_i[15];
          vflip_d = ram_data_i[14];
          pal_d   = ram_data_i[PW-5:0];
        end
        default: ;
      endcase
    end

    // Leaving WAIT: a pending or simultaneous edge restarts from object 0
    if (state_q == c_ST_WAIT && !busy_i) begin
      if (pend_q || w_edge) begin
        idx_d  = '0;
        pend_d = 1'b0;
      end else if (!w_last) begin
        idx_d = idx_q + c_IDX_ONE;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      vl_q    <= '0;
      pend_q  <= 1'b0;
      code_q  <= '0;
      xpos_q  <= '0;
      ysub_q  <= '0;
      hflip_q <= 1'b0;
      vflip_q <= 1'b0;
      pal_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      vl_q    <= vl_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      xpos_q  <= xpos_d;
      ysub_q  <= ysub_d;
      hflip_q <= hflip_d;
      vflip_q <= vflip_d;
      pal_q   <= pal_d;
    end
  end

  // Outputs; the RAM address runs one word ahead so each word lands the
  // clock after it is addressed (word 1 is fetched speculatively in CHK)
  always_comb begin
    ram_addr_o  = {idx_q, 2'd0};
    case (state_q)
      c_ST_CHK: ram_addr_o = {idx_q, 2'd1};
      c_ST_RD1: ram_addr_o = {idx_q, 2'd2};
      c_ST_RD2: ram_addr_o = {idx_q, 2'd3};
      default:  ram_addr_o = {idx_q, 2'd0};
    endcase
    draw_o      = (state_q == c_ST_ISSUE);
    scan_done_o = ~w_scan_st;
    overrun_o   = w_edge & w_scan_st;
  end

  assign code_o  = code_q;
  assign xpos_o  = xpos_q;
  assign ysub_o  = ysub_q;
  assign hflip_o = hflip_q;
  assign vflip_o = vflip_q;
  assign pal_o   = pal_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_objscan.sv
// ============================================================================
//  Module      : tb_jtframe_objscan
//  Description : Self-checking bench for jtframe_objscan with a RAM model,
//                a busy-responding draw engine and a per-line draw list model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtframe_objscan;

  localparam int CW   = 12;
  localparam int PW   = 8;
  localparam int OW   = 7;
  localparam int NOBJ = 1 << OW;

  typedef struct packed {
    logic [CW-1:0] code;
    logic [8:0]    xpos;
    logic [3:0]    ysub;
    logic          hf;
    logic          vf;
    logic [PW-5:0] pal;
  } draw_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hs = 1'b0;
  logic          busy = 1'b0;
  logic [8:0]    vrender = '0;
  logic [OW+1:0] ram_addr;
  logic [15:0]   ram_data = '0;
  logic          draw;
  logic [CW-1:0] code;
  logic [8:0]    xpos;
  logic [3:0]    ysub;
  logic          hflip, vflip;
  logic [PW-5:0] pal;
  logic          scan_done, overrun;

  logic [15:0] mem [0:4*NOBJ-1];
  draw_t exp_q[$];
  draw_t last_draw;
  int checks = 0, errors = 0;
  int draws_seen = 0, ovr_cnt = 0, busy_len = 0;

  jtframe_objscan #(.CW(CW), .PW(PW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .hs_i(hs), .vrender_i(vrender),
    .ram_addr_o(ram_addr), .ram_data_i(ram_data), .draw_o(draw), .busy_i(busy),
    .code_o(code), .xpos_o(xpos), .ysub_o(ysub), .hflip_o(hflip), .vflip_o(vflip),
    .pal_o(pal), .scan_done_o(scan_done), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read object RAM
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: every enabled object whose 16-line band covers vl, in table order
  task automatic load_exp(input logic [8:0] vl);
    int d;
    draw_t e;
    exp_q.delete();
    for (int i = 0; i < NOBJ; i++) begin
      d = (int'(vl) - int'(mem[4*i][8:0]) + 512) % 512;
      if (mem[4*i][15] && d < 16) begin
        e.code = mem[4*i+1][CW-1:0];
        e.xpos = mem[4*i+2][8:0];
        e.ysub = 4'(d);
        e.hf   = mem[4*i+3][15];
        e.vf   = mem[4*i+3][14];
        e.pal  = mem[4*i+3][PW-5:0];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4*NOBJ; i++) mem[i] = '0;
  endtask

  // Draw engine: take each request, raise busy the next clock, hold it and
  // watch that the request fields stay put and no new draw appears
  initial begin : responder
    draw_t got;
    int n;
    forever begin
      @(negedge clk);
      if (rst_n && draw) begin
        got = {code, xpos, ysub, hflip, vflip, pal};
        draws_seen++;
        last_draw = got;
        chk("draw_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("draw_fields", got, exp_q.pop_front());
        n = (busy_len != 0) ? busy_len : int'($urandom_range(1, 6));
        @(posedge clk);
        #1 busy = 1'b1;
        for (int c = 0; c < n; c++) begin
          @(negedge clk);
          if (!rst_n) break;
          chk("hold_fields", {code, xpos, ysub, hflip, vflip, pal}, got);
          chk("no_draw_busy", draw, 0);
        end
        busy = 1'b0;
      end
    end
  end

  initial begin : ovr_mon
    forever begin
      @(negedge clk);
      if (rst_n && overrun) ovr_cnt++;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start a scan of line vl and wait (bounded) for scan_done; returns the
  // number of clocks from the first clock that sees hs high
  task automatic run_scan(input logic [8:0] vl, output int cyc);
    load_exp(vl);
    vrender = vl;
    @(negedge clk);
    hs  = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 2) chk("scan_started", scan_done, 0);
      if (n == 4) hs = 1'b0;
      if (n > 2 && scan_done) begin
        cyc = n;
        break;
      end
    end
    hs = 1'b0;
    if (cyc == 0) chk("scan_timeout", scan_done, 1);
    chk("exp_drained", exp_q.size(), 0);
  endtask

  task automatic wait_draw(input int d0);
    int ok;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (draws_seen != d0) begin
        ok = 1;
        break;
      end
    end
    chk("draw_arrived", ok, 1);
  endtask

  initial begin : main
    int cyc, d0, o0;
    clear_mem();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_scan_done", scan_done, 1);
    chk("rst_draw", draw, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fields", {code, xpos, ysub, hflip, vflip, pal}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All objects disabled: pure rejection timing, no draws
    d0 = draws_seen;
    run_scan(9'h025, cyc);
    chk("reject_timing", (cyc >= 257 && cyc <= 259), 1);
    chk("reject_draws", draws_seen - d0, 0);

    // Single visible object
    mem[20] = 16'h8020; mem[21] = 16'h0123; mem[22] = 16'h0040; mem[23] = 16'h8003;
    busy_len = 20;
    d0 = draws_seen;
    run_scan(9'h025, cyc);
    chk("single_count", draws_seen - d0, 1);
    chk("single_code", last_draw.code, 12'h123);
    chk("single_xpos", last_draw.xpos, 9'h040);
    chk("single_ysub", last_draw.ysub, 4'h5);
    chk("single_flip", {last_draw.hf, last_draw.vf}, 2'b10);
    chk("single_pal", last_draw.pal, 4'h3);
    d0 = draws_seen;
    run_scan(9'h01F, cyc);
    run_scan(9'h030, cyc);
    chk("single_outside", draws_seen - d0, 0);

    // Reset while the engine is busy with a request
    d0 = draws_seen;
    load_exp(9'h02A);
    vrender = 9'h02A;
    @(negedge clk); hs = 1'b1;
    repeat (3) @(negedge clk); hs = 1'b0;
    wait_draw(d0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_draw", draw, 0);
    chk("midrst_scan_done", scan_done, 1);
    chk("midrst_fields", {code, xpos, ysub, hflip, vflip, pal}, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_idle", {scan_done, draw}, 2'b10);
    end

    // Line wrap at 511/0
    clear_mem();
    mem[160] = 16'h81F8; mem[161] = 16'h0ABC; mem[162] = 16'h01FF; mem[163] = 16'h4005;
    d0 = draws_seen;
    run_scan(9'h002, cyc);
    chk("wrap_count", draws_seen - d0, 1);
    chk("wrap_ysub", last_draw.ysub, 4'hA);
    chk("wrap_vflip", {last_draw.hf, last_draw.vf}, 2'b01);
    d0 = draws_seen;
    run_scan(9'h008, cyc);
    chk("wrap_none", draws_seen - d0, 0);

    // Overrun while waiting on busy: restart with the new line afterwards
    clear_mem();
    mem[20] = 16'h8040; mem[21] = 16'h0111; mem[22] = 16'h0011; mem[23] = 16'h0001;
    mem[36] = 16'h8044; mem[37] = 16'h0222; mem[38] = 16'h0022; mem[39] = 16'h0002;
    mem[80] = 16'h80F8; mem[81] = 16'h0333; mem[82] = 16'h0033; mem[83] = 16'h8007;
    busy_len = 20;
    d0 = draws_seen;
    load_exp(9'h045);
    vrender = 9'h045;
    @(negedge clk); hs = 1'b1;
    repeat (3) @(negedge clk); hs = 1'b0;
    wait_draw(d0);
    chk("ovr_first_code", last_draw.code, 12'h111);
    repeat (4) @(negedge clk);
    o0 = ovr_cnt;
    load_exp(9'h100);
    vrender = 9'h100;
    hs = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 4) hs = 1'b0;
    end
    chk("ovr_pulses", ovr_cnt - o0, 1);
    cyc = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (scan_done) begin
        cyc = 1;
        break;
      end
    end
    chk("ovr_scan_done", cyc, 1);
    chk("ovr_exp_drained", exp_q.size(), 0);
    chk("ovr_draw_total", draws_seen - d0, 2);
    chk("ovr_last_code", last_draw.code, 12'h333);
    chk("ovr_last_ysub", last_draw.ysub, 4'h8);

    // Randomized tables and lines
    busy_len = 0;
    for (int r = 0; r < 6; r++) begin
      logic [8:0] vl;
      for (int i = 0; i < NOBJ; i++) begin
        mem[4*i]   = {($urandom_range(0, 3) == 0), 6'($urandom), 9'($urandom)};
        mem[4*i+1] = 16'($urandom);
        mem[4*i+2] = 16'($urandom);
        mem[4*i+3] = 16'($urandom);
      end
      vl = 9'($urandom);
      for (int k = 0; k < 4; k++) begin
        int j;
        j = int'($urandom_range(0, NOBJ-1));
        mem[4*j] = {1'b1, 6'd0, 9'(vl - 9'($urandom_range(0, 20)))};
      end
      run_scan(vl, cyc);
      run_scan(9'($urandom), cyc);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
